// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised integer register file for the CPU datapath.
// After reset it zeroes every entry, one per clock. It forwards a same-cycle
// write to the read ports when BYPASS=1. It keeps one pending-write bit per
// register so that decode can detect RAW hazards. Register 0 always reads 0.
//
// Ports
//   clk       : system clock, rising edge
//   rst       : asynchronous active-high reset
//   init_busy : high while the clear sequencer runs (pipeline must stall)
//   rs1, rs2  : read addresses
//   rd1, rd2  : combinational read data
//   we/wa/wd  : writeback enable / address / data
//   iss_valid : an instruction with a destination issues this cycle
//   iss_rd    : destination register of the issuing instruction
//   rs1_pend  : source 1 has an outstanding write not satisfied this cycle
//   rs2_pend  : source 2 has an outstanding write not satisfied this cycle
module reg_file_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            init_busy,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    output logic            rs1_pend,
    output logic            rs2_pend
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [AW-1:0]   clr_ptr_q, clr_ptr_d;
    logic [NREG-1:0] pend_q, pend_d;
    logic [XLEN-1:0] regs_q [NREG];
    logic            run_s;
    logic            wr_en_s;

    // Read-port value for one source address. A same-cycle write wins over the
    // stored value only when forwarding is enabled. Address 0 is always zero.
    function automatic logic [XLEN-1:0] read_port(
        input logic            run,
        input logic [AW-1:0]   ra,
        input logic            we_v,
        input logic [AW-1:0]   wa_v,
        input logic [XLEN-1:0] wd_v,
        input logic [XLEN-1:0] stored
    );
        logic [XLEN-1:0] res;
        if (!run || ra == '0) begin
            res = '0;
        end else if (BYPASS != 0 && we_v && wa_v == ra) begin
            res = wd_v;
        end else begin
            res = stored;
        end
        return res;
    endfunction

    // Pending indication for one source. Forwarding satisfies the hazard in the
    // write cycle itself. Without forwarding the consumer waits for the array.
    function automatic logic pend_port(
        input logic            run,
        input logic [AW-1:0]   ra,
        input logic            we_v,
        input logic [AW-1:0]   wa_v,
        input logic            pend_bit
    );
        logic res;
        if (!run) begin
            res = 1'b0;
        end else if (BYPASS != 0 && we_v && wa_v == ra) begin
            res = 1'b0;
        end else begin
            res = pend_bit;
        end
        return res;
    endfunction

    assign run_s     = (state_q == ST_RUN);
    assign init_busy = (state_q == ST_CLEAR);
    assign wr_en_s   = run_s && we && (wa != '0);

    // Clear sequencer: walk clr_ptr across the array, then enter RUN.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            ST_CLEAR: begin
                clr_ptr_d = clr_ptr_q + AW'(1);
                if (clr_ptr_q == AW'(NREG - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_RUN: begin
                state_d   = ST_RUN;
                clr_ptr_d = clr_ptr_q;
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_ptr_d = '0;
            end
        endcase
    end

    // Scoreboard next state: issue sets, writeback clears, set wins on a tie.
    always_comb begin
        pend_d = '0;
        if (run_s) begin
            for (int i = 1; i < NREG; i++) begin
                if (iss_valid && iss_rd == AW'(i)) begin
                    pend_d[i] = 1'b1;
                end else if (we && wa == AW'(i)) begin
                    pend_d[i] = 1'b0;
                end else begin
                    pend_d[i] = pend_q[i];
                end
            end
        end else begin
            pend_d = '0;
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
            pend_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            pend_q    <= pend_d;
        end
    end

    // Storage array. It has no reset; the clear sequencer zeroes it.
    // While rst is held, clr_ptr stays 0, so only entry 0 is rewritten.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            regs_q[clr_ptr_q] <= '0;
        end else if (wr_en_s) begin
            regs_q[wa] <= wd;
        end else begin
            regs_q[wa] <= regs_q[wa];
        end
    end

    // Combinational read and hazard outputs.
    always_comb begin
        rd1      = read_port(run_s, rs1, we, wa, wd, regs_q[rs1]);
        rd2      = read_port(run_s, rs2, we, wa, wd, regs_q[rs2]);
        rs1_pend = pend_port(run_s, rs1, we, wa, pend_q[rs1]);
        rs2_pend = pend_port(run_s, rs2, we, wa, pend_q[rs2]);
    end

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1, rs2, wa, iss_rd;
    logic        we, iss_valid;
    logic [31:0] wd;

    logic        busy_b1, busy_b0;
    logic [31:0] rd1_b1, rd2_b1, rd1_b0, rd2_b0;
    logic        p1_b1, p2_b1, p1_b0, p2_b0;

    int total = 0;
    int bad   = 0;
    int n;

    reg_file_sb #(.XLEN(32), .NREG(32), .BYPASS(1)) u_b1 (
        .clk(clk), .rst(rst), .init_busy(busy_b1),
        .rs1(rs1), .rs2(rs2), .rd1(rd1_b1), .rd2(rd2_b1),
        .we(we), .wa(wa), .wd(wd),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .rs1_pend(p1_b1), .rs2_pend(p2_b1)
    );

    reg_file_sb #(.XLEN(32), .NREG(32), .BYPASS(0)) u_b0 (
        .clk(clk), .rst(rst), .init_busy(busy_b0),
        .rs1(rs1), .rs2(rs2), .rd1(rd1_b0), .rd2(rd2_b0),
        .we(we), .wa(wa), .wd(wd),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .rs1_pend(p1_b0), .rs2_pend(p2_b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 2 time units after it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; rs1 = 5'd5; rs2 = 5'd7; wa = 5'd0; iss_rd = 5'd0;
        we = 1'b0; iss_valid = 1'b0; wd = 32'd0;
        tick(); tick();
        #1;
        chk("rst_busy_b1", 64'(busy_b1), 64'd1);
        chk("rst_busy_b0", 64'(busy_b0), 64'd1);
        chk("rst_rd1", 64'(rd1_b1), 64'd0);
        chk("rst_rd2", 64'(rd2_b1), 64'd0);
        chk("rst_p1", 64'(p1_b1), 64'd0);
        chk("rst_p2", 64'(p2_b1), 64'd0);

        // Release reset and count busy cycles. From edge 5 on, drive a write to
        // register 1, which is already cleared, plus an issue to register 2.
        // Both must be ignored while clearing.
        rst = 1'b0;
        n = 0;
        while (busy_b1 && n < 100) begin
            if (n >= 5) begin
                we = 1'b1; wa = 5'd1; wd = 32'hFFFF_FFFF;
                iss_valid = 1'b1; iss_rd = 5'd2;
            end
            tick();
            n++;
        end
        we = 1'b0; iss_valid = 1'b0;
        #1;
        chk("clear_cycles", 64'(n), 64'd32);
        chk("clear_busy_b0", 64'(busy_b0), 64'd0);

        for (int r = 0; r < 32; r++) begin
            rs1 = 5'(r); rs2 = 5'(31 - r);
            #1;
            chk("sweep_rd1_b1", 64'(rd1_b1), 64'd0);
            chk("sweep_rd2_b1", 64'(rd2_b1), 64'd0);
            chk("sweep_rd1_b0", 64'(rd1_b0), 64'd0);
            chk("sweep_p1_b1", 64'(p1_b1), 64'd0);
            chk("sweep_p2_b0", 64'(p2_b0), 64'd0);
        end

        // Write 5 and read it in the same cycle.
        rs1 = 5'd5; we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF;
        #1;
        chk("byp_rd1_b1", 64'(rd1_b1), 64'hDEAD_BEEF);
        chk("byp_rd1_b0", 64'(rd1_b0), 64'd0);
        tick();
        we = 1'b0; wd = 32'd0;
        #1;
        chk("wr5_rd1_b1", 64'(rd1_b1), 64'hDEAD_BEEF);
        chk("wr5_rd1_b0", 64'(rd1_b0), 64'hDEAD_BEEF);

        // Writes to register 0 are discarded and never forwarded.
        rs2 = 5'd0; we = 1'b1; wa = 5'd0; wd = 32'h1234_5678;
        #1;
        chk("w0_byp_rd2_b1", 64'(rd2_b1), 64'd0);
        tick();
        we = 1'b0;
        #1;
        chk("w0_rd2_b1", 64'(rd2_b1), 64'd0);
        chk("w0_rd2_b0", 64'(rd2_b0), 64'd0);
        iss_valid = 1'b1; iss_rd = 5'd0;
        tick();
        iss_valid = 1'b0;
        #1;
        chk("iss0_p2_b1", 64'(p2_b1), 64'd0);
        chk("iss0_p2_b0", 64'(p2_b0), 64'd0);

        // Issue to 7, then writeback to 7.
        rs1 = 5'd7; iss_valid = 1'b1; iss_rd = 5'd7;
        #1;
        chk("iss7_pre_p1", 64'(p1_b1), 64'd0);
        tick();
        iss_valid = 1'b0;
        #1;
        chk("iss7_p1_b1", 64'(p1_b1), 64'd1);
        chk("iss7_p1_b0", 64'(p1_b0), 64'd1);
        we = 1'b1; wa = 5'd7; wd = 32'h0000_0077;
        #1;
        chk("wb7_p1_b1", 64'(p1_b1), 64'd0);
        chk("wb7_p1_b0", 64'(p1_b0), 64'd1);
        chk("wb7_rd1_b1", 64'(rd1_b1), 64'h77);
        tick();
        we = 1'b0;
        #1;
        chk("wb7_after_p1_b1", 64'(p1_b1), 64'd0);
        chk("wb7_after_p1_b0", 64'(p1_b0), 64'd0);
        chk("wb7_after_rd1_b0", 64'(rd1_b0), 64'h77);

        // Issue and writeback to 9 on the same edge: set wins.
        rs2 = 5'd9; iss_valid = 1'b1; iss_rd = 5'd9;
        we = 1'b1; wa = 5'd9; wd = 32'h0000_0055;
        tick();
        iss_valid = 1'b0; we = 1'b0;
        #1;
        chk("tie9_p2_b1", 64'(p2_b1), 64'd1);
        chk("tie9_p2_b0", 64'(p2_b0), 64'd1);
        chk("tie9_rd2_b1", 64'(rd2_b1), 64'h55);
        chk("tie9_rd2_b0", 64'(rd2_b0), 64'h55);
        chk("tie9_p1_unrel", 64'(p1_b1), 64'd0);

        // Prepare register 3 (value 0xAA, pending) and reset mid-run.
        we = 1'b1; wa = 5'd3; wd = 32'h0000_00AA;
        tick();
        we = 1'b0; iss_valid = 1'b1; iss_rd = 5'd3; rs1 = 5'd3;
        tick();
        iss_valid = 1'b0;
        #1;
        chk("pre_rst_rd1", 64'(rd1_b1), 64'hAA);
        chk("pre_rst_p1", 64'(p1_b1), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(busy_b1), 64'd1);
        chk("mid_rst_rd1", 64'(rd1_b1), 64'd0);
        chk("mid_rst_p1", 64'(p1_b1), 64'd0);
        tick();
        rst = 1'b0;
        n = 0;
        while (busy_b1 && n < 100) begin
            if (n >= 6) begin
                we = 1'b1; wa = 5'd3; wd = 32'h0000_00BB;
            end
            tick();
            n++;
        end
        we = 1'b0;
        #1;
        chk("reclear_cycles", 64'(n), 64'd32);
        chk("reclear_rd1_b1", 64'(rd1_b1), 64'd0);
        chk("reclear_rd1_b0", 64'(rd1_b0), 64'd0);
        chk("reclear_p1_b1", 64'(p1_b1), 64'd0);
        chk("reclear_p1_b0", 64'(p1_b0), 64'd0);
        rs2 = 5'd9;
        #1;
        chk("reclear_p2_r9", 64'(p2_b1), 64'd0);
        chk("reclear_rd2_r9", 64'(rd2_b1), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
